xbus_arbiter: RTL

Two-master arbiter that shares the single-port, synchronous-read `ram` xbus slave between the instruction-fetch port (m0) and the load/store port (m1). Grants at most one access per cycle with round-robin fairness and drives the RAM's xbus inputs directly. Tracks the one-cycle read latency and routes the response back to the issuing master. Rejects out-of-window addresses with an error response without touching the RAM.

---
 rtl/xbus_arbiter_pkg.sv | 25 ++
 rtl/xbus_arbiter_rr_arb2.sv | 43 ++++
 rtl/xbus_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/xbus_arbiter_pkg.sv
// Shared xbus widths, master ids and the RAM window check.
// Imported by the arbiter top and its round-robin picker.
package xbus_arbiter_pkg;

    localparam int XADDRW  = 32;
    localparam int XDATAW  = 32;
    localparam int XBYTEC  = 4;
    localparam int BYTEW   = 8;
    localparam int XWORDSH = 2;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } mst_e;

    // Unsigned subtract also rejects addresses below base.
    function automatic logic in_window(
        input logic [XADDRW-1:0] addr,
        input logic [XADDRW-1:0] base,
        input logic [XADDRW-1:0] size
    );
        return (addr - base) < size;
    endfunction

endpackage

// File: rtl/xbus_arbiter_rr_arb2.sv
// Two-way round-robin picker.
// The last register points at the most recent winner.
module rr_arb2
    import xbus_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    mst_e last_q;
    mst_e last_d;

    always_comb begin
        gnt_o = 2'b00;
        if (!rst_n) begin
            gnt_o = 2'b00;
        end else if (req_i == 2'b11) begin
            gnt_o = (last_q == M1) ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt_o[1]) begin
            last_d = M1;
        end else if (gnt_o[0]) begin
            last_d = M0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= M1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/xbus_arbiter.sv
// Shares one synchronous-read xbus RAM between fetch (m0) and load/store (m1).
// Out-of-window accesses get an error response and never reach the RAM.
module xbus_arbiter
    import xbus_arbiter_pkg::*;
#(
    parameter logic [XADDRW-1:0] BASE  = 32'h0000_0000,
    parameter int                DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [XBYTEC-1:0] m0_be,
    input  logic [XADDRW-1:0] m0_addr,
    input  logic [XDATAW-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic              m0_err,
    output logic [XDATAW-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [XBYTEC-1:0] m1_be,
    input  logic [XADDRW-1:0] m1_addr,
    input  logic [XDATAW-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic              m1_err,
    output logic [XDATAW-1:0] m1_rdata,

    output logic              xbus_cs,
    output logic              xbus_we,
    output logic [XBYTEC-1:0] xbus_be,
    output logic [XADDRW-1:0] xbus_addr,
    output logic [XDATAW-1:0] xbus_wdata,
    input  logic [XDATAW-1:0] xbus_rdata
);

    localparam logic [XADDRW-1:0] WIN_SZ = XADDRW'(DEPTH) << XWORDSH;

    logic [1:0]        gnt;
    logic              any_gnt;
    mst_e              win;
    logic              sel_we;
    logic [XBYTEC-1:0] sel_be;
    logic [XADDRW-1:0] sel_addr;
    logic [XDATAW-1:0] sel_wdata;
    logic              in_win;

    logic rsp_vld_q, rsp_vld_d;
    mst_e rsp_sel_q, rsp_sel_d;
    logic rsp_err_q, rsp_err_d;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i ({m1_req, m0_req}),
        .gnt_o (gnt)
    );

    assign any_gnt = |gnt;
    assign win     = gnt[1] ? M1 : M0;
    assign m0_gnt  = gnt[0];
    assign m1_gnt  = gnt[1];

    // Idle cycles fall through to m0, so no separate idle mux leg.
    always_comb begin
        sel_we    = m0_we;
        sel_be    = m0_be;
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        if (win == M1) begin
            sel_we    = m1_we;
            sel_be    = m1_be;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
        end
    end

    assign in_win     = in_window(sel_addr, BASE, WIN_SZ);
    assign xbus_cs    = any_gnt & in_win;
    assign xbus_we    = sel_we;
    assign xbus_be    = sel_we ? sel_be : '0;
    assign xbus_addr  = sel_addr;
    assign xbus_wdata = sel_wdata;

    always_comb begin
        rsp_vld_d = any_gnt;
        rsp_sel_d = win;
        rsp_err_d = any_gnt & ~in_win;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_q <= 1'b0;
            rsp_sel_q <= M0;
            rsp_err_q <= 1'b0;
        end else begin
            rsp_vld_q <= rsp_vld_d;
            rsp_sel_q <= rsp_sel_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign m0_rvalid = rsp_vld_q & (rsp_sel_q == M0);
    assign m1_rvalid = rsp_vld_q & (rsp_sel_q == M1);
    assign m0_err    = m0_rvalid & rsp_err_q;
    assign m1_err    = m1_rvalid & rsp_err_q;
    assign m0_rdata  = (m0_rvalid & ~rsp_err_q) ? xbus_rdata : '0;
    assign m1_rdata  = (m1_rvalid & ~rsp_err_q) ? xbus_rdata : '0;

endmodule
